// File: rtl/timer_avalon_master.sv
//==============================================================================
// Module   : timer_avalon_master
// Brief    : Avalon-MM initiator that programs, services and snapshots the
//            interval timer's 16-bit register slave without CPU involvement.
//            `define TIMER_AVALON_MASTER_POLL_EN to poll status instead of irq.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module timer_avalon_master #(
  parameter int ADDR_W        = 3,
  parameter int DATA_W        = 16,
  parameter int CNT_W         = 16,
  parameter int POLL_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic [31:0]       cfg_period,
  input  logic              snap_req,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [CNT_W-1:0]  tick_count,
  output logic              snap_valid,
  output logic [31:0]       snap_value,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              timer_irq
);

  localparam logic [3:0] c_IDLE    = 4'd0;
  localparam logic [3:0] c_WR_PL   = 4'd1;
  localparam logic [3:0] c_WR_PH   = 4'd2;
  localparam logic [3:0] c_WR_CTRL = 4'd3;
  localparam logic [3:0] c_RUN     = 4'd4;
  localparam logic [3:0] c_CLR_STS = 4'd5;
  localparam logic [3:0] c_SNAP_WR = 4'd6;
  localparam logic [3:0] c_RD_L    = 4'd7;
  localparam logic [3:0] c_RD_WAIT = 4'd8;
  localparam logic [3:0] c_RD_H    = 4'd9;
  localparam logic [3:0] c_STOP_WR = 4'd10;
  localparam logic [3:0] c_RD_ST   = 4'd11;

  localparam logic [15:0] c_CTRL_STOP = 16'h0008;

  logic [3:0]        r_state;
  logic [3:0]        w_state_nxt;
  logic [3:0]        r_rd_src;
  logic [31:0]       r_period;
  logic [DATA_W-1:0] r_snap_lo;
  logic              r_snap_run;
  logic              w_done;
  logic              w_service;

`ifdef TIMER_AVALON_MASTER_POLL_EN
  localparam logic [15:0] c_CTRL_START = 16'h0006;
  localparam logic [3:0]  c_SERVICE_ST = c_RD_ST;
  localparam int          c_POLL_W     = $clog2(POLL_INTERVAL + 1);

  logic [c_POLL_W-1:0] r_poll_cnt;
  logic                w_poll_due;
  logic                w_irq_unused;

  assign w_irq_unused = timer_irq;
  assign w_poll_due   = (r_poll_cnt == c_POLL_W'(POLL_INTERVAL - 1));
  assign w_service    = w_poll_due;

  // Counter restarts every time RUN is (re)entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_poll_cnt <= '0;
    else if (r_state != c_RUN)
      r_poll_cnt <= '0;
    else if (!w_poll_due)
      r_poll_cnt <= r_poll_cnt + c_POLL_W'(1);
  end
`else
  localparam logic [15:0] c_CTRL_START = 16'h0007;
  localparam logic [3:0]  c_SERVICE_ST = c_CLR_STS;
  localparam int          c_poll_unused = POLL_INTERVAL;

  assign w_service = timer_irq;
`endif

  // Bus outputs decode straight from the state register, so they are stable
  // for the whole access and drop to idle the instant reset asserts.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = '0;
    avm_writedata  = '0;
    case (r_state)
      c_WR_PL:   begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = ADDR_W'(2);
                       avm_writedata = DATA_W'(r_period[15:0]); end
      c_WR_PH:   begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = ADDR_W'(3);
                       avm_writedata = DATA_W'(r_period[31:16]); end
      c_WR_CTRL: begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = ADDR_W'(1);
                       avm_writedata = DATA_W'(c_CTRL_START); end
      c_CLR_STS: begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = ADDR_W'(0); end
      c_SNAP_WR: begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = ADDR_W'(4); end
      c_STOP_WR: begin avm_chipselect = 1'b1; avm_write_n = 1'b0; avm_address = ADDR_W'(1);
                       avm_writedata = DATA_W'(c_CTRL_STOP); end
      c_RD_L:    begin avm_chipselect = 1'b1; avm_address = ADDR_W'(4); end
      c_RD_H:    begin avm_chipselect = 1'b1; avm_address = ADDR_W'(5); end
      c_RD_ST:   begin avm_chipselect = 1'b1; avm_address = ADDR_W'(0); end
      default:   ;
    endcase
  end

  assign w_done = avm_chipselect & ~avm_waitrequest;
  assign busy   = (r_state != c_IDLE) && (r_state != c_RUN);
  assign tick   = (r_state == c_CLR_STS) & w_done;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE, c_RUN: begin
        if (cfg_stop)                           w_state_nxt = c_STOP_WR;
        else if (cfg_start)                     w_state_nxt = c_WR_PL;
        else if (snap_req)                      w_state_nxt = c_SNAP_WR;
        else if ((r_state == c_RUN) && w_service) w_state_nxt = c_SERVICE_ST;
      end
      c_WR_PL:   if (w_done) w_state_nxt = c_WR_PH;
      c_WR_PH:   if (w_done) w_state_nxt = c_WR_CTRL;
      c_WR_CTRL: if (w_done) w_state_nxt = c_RUN;
      c_CLR_STS: if (w_done) w_state_nxt = c_RUN;
      c_SNAP_WR: if (w_done) w_state_nxt = c_RD_L;
      c_RD_L:    if (w_done) w_state_nxt = c_RD_WAIT;
      c_RD_H:    if (w_done) w_state_nxt = c_RD_WAIT;
      c_RD_ST:   if (w_done) w_state_nxt = c_RD_WAIT;
      c_STOP_WR: if (w_done) w_state_nxt = c_IDLE;
      c_RD_WAIT: begin
        if (r_rd_src == c_RD_L)
          w_state_nxt = c_RD_H;
`ifdef TIMER_AVALON_MASTER_POLL_EN
        else if (r_rd_src == c_RD_ST)
          w_state_nxt = avm_readdata[0] ? c_CLR_STS : c_RUN;
`endif
        else
          w_state_nxt = r_snap_run ? c_RUN : c_IDLE;
      end
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_IDLE;
      r_rd_src   <= c_IDLE;
      r_period   <= '0;
      r_snap_lo  <= '0;
      r_snap_run <= 1'b0;
      running    <= 1'b0;
      tick_count <= '0;
      snap_valid <= 1'b0;
      snap_value <= '0;
    end else begin
      r_state    <= w_state_nxt;
      snap_valid <= 1'b0;
      if ((w_state_nxt == c_WR_PL) && (r_state != c_WR_PL)) begin
        r_period   <= cfg_period;
        tick_count <= '0;
      end else if (tick) begin
        tick_count <= tick_count + CNT_W'(1);
      end
      if ((w_state_nxt == c_SNAP_WR) && (r_state != c_SNAP_WR))
        r_snap_run <= (r_state == c_RUN);
      // Remember which read led into RD_WAIT so the sample can be routed.
      if ((w_state_nxt == c_RD_WAIT) && (r_state != c_RD_WAIT))
        r_rd_src <= r_state;
      if ((r_state == c_RD_WAIT) && (r_rd_src == c_RD_L))
        r_snap_lo <= avm_readdata;
      if ((r_state == c_RD_WAIT) && (r_rd_src == c_RD_H)) begin
        snap_value <= 32'({avm_readdata, r_snap_lo});
        snap_valid <= 1'b1;
      end
      if ((r_state == c_WR_CTRL) && w_done)
        running <= 1'b1;
      else if ((r_state == c_STOP_WR) && w_done)
        running <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_timer_avalon_master.sv
//==============================================================================
// Module   : tb_timer_avalon_master
// Brief    : Self-checking bench for timer_avalon_master with a timer slave model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_timer_avalon_master;

  typedef struct packed {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [31:0] cfg_period = '0;
  logic        snap_req = 1'b0;
  logic        busy, running, tick, snap_valid;
  logic [15:0] tick_count;
  logic [31:0] snap_value;
  logic [2:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail = 0;
  acc_t exp_q[$];
  acc_t obs_q[$];
  acc_t mon_a, e, o;

  // Timer slave model state
  logic [15:0] m_pl = '0, m_ph = '0;
  logic        m_to = 1'b0, m_ito = 1'b0, m_run = 1'b0;
  logic [31:0] m_cnt = '0, m_snap = '0, snap_src = '0;
  int          force_req = 0, force_seen = 0;

  timer_avalon_master #(.ADDR_W(3), .DATA_W(16), .CNT_W(16), .POLL_INTERVAL(64)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_period(cfg_period), .snap_req(snap_req), .busy(busy), .running(running),
    .tick(tick), .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  assign timer_irq = m_to & m_ito;

  always @(posedge clk) begin
    if (m_run) begin
      if (m_cnt >= {m_ph, m_pl}) begin m_cnt <= '0; m_to <= 1'b1; end
      else m_cnt <= m_cnt + 1;
    end
    if (force_req != force_seen) begin force_seen <= force_req; m_to <= 1'b1; end
    if (avm_chipselect && !avm_waitrequest) begin
      mon_a.we   = !avm_write_n;
      mon_a.addr = avm_address;
      mon_a.data = avm_write_n ? 16'h0 : avm_writedata;
      obs_q.push_back(mon_a);
      if (!avm_write_n) begin
        case (avm_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito <= avm_writedata[0];
            if (avm_writedata[2]) begin m_run <= 1'b1; m_cnt <= '0; end
            if (avm_writedata[3]) m_run <= 1'b0;
          end
          3'd2: m_pl <= avm_writedata;
          3'd3: m_ph <= avm_writedata;
          3'd4: m_snap <= snap_src;
          default: ;
        endcase
      end else begin
        case (avm_address)
          3'd0: avm_readdata <= {15'h0, m_to};
          3'd4: avm_readdata <= m_snap[15:0];
          3'd5: avm_readdata <= m_snap[31:16];
          default: avm_readdata <= 16'h0;
        endcase
      end
    end
  end

  function automatic acc_t mk(input logic we, input logic [2:0] addr, input logic [15:0] data);
    acc_t a;
    a.we = we; a.addr = addr; a.data = data;
    return a;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) begin n_fail++;
      $display("FAIL reset_bus: cs=%b wn=%b want cs=0 wn=1", avm_chipselect, avm_write_n); end
    n_checks++; if ({busy, running, tick, snap_valid} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {busy, running, tick, snap_valid}); end
    n_checks++; if (tick_count !== 16'h0 || snap_value !== 32'h0 || avm_address !== 3'h0 || avm_writedata !== 16'h0) begin n_fail++;
      $display("FAIL reset_values: cnt=%h snap=%h addr=%h wd=%h want 0", tick_count, snap_value, avm_address, avm_writedata); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start(input logic [31:0] period);
    obs_q.delete();
    exp_q.push_back(mk(1'b1, 3'd2, period[15:0]));
    exp_q.push_back(mk(1'b1, 3'd3, period[31:16]));
    exp_q.push_back(mk(1'b1, 3'd1, 16'h0007));
    cfg_period = period; cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy); end
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || running !== 1'b1) begin n_fail++;
      $display("FAIL start_done: busy=%b running=%b want 0 1", busy, running); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL start_bus: got %h want %h", o, e); end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL start_extra: got %0d extra want 0", obs_q.size()); end
    n_checks++; if (tick_count !== 16'h0) begin n_fail++; $display("FAIL start_cnt: got %h want 0", tick_count); end
  endtask

  task automatic test_ticks();
    int ticks = 0;
    int cyc = 0;
    obs_q.delete();
    repeat (5) exp_q.push_back(mk(1'b1, 3'd0, 16'h0000));
    while (ticks < 5 && cyc < 30000) begin
      @(negedge clk); cyc++;
      if (tick === 1'b1) begin
        ticks++;
        n_checks++; if (!(avm_chipselect && !avm_write_n && avm_address == 3'd0 && avm_writedata == 16'h0)) begin n_fail++;
          $display("FAIL tick_bus: cs=%b wn=%b addr=%h wd=%h want addr0 write 0", avm_chipselect, avm_write_n, avm_address, avm_writedata); end
        @(negedge clk); cyc++;
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b want 0", timer_irq); end
      end
    end
    n_checks++; if (ticks != 5) begin n_fail++; $display("FAIL tick_timeout: got %0d ticks want 5", ticks); end
    n_checks++; if (tick_count !== 16'd5) begin n_fail++; $display("FAIL tick_count: got %0d want 5", tick_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL tick_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_snapshot();
    int pulses = 0;
    logic [31:0] got = '0;
    obs_q.delete();
    snap_src = 32'h0002_1A3F;
    exp_q.push_back(mk(1'b1, 3'd4, 16'h0));
    exp_q.push_back(mk(1'b0, 3'd4, 16'h0));
    exp_q.push_back(mk(1'b0, 3'd5, 16'h0));
    snap_req = 1'b1;
    @(negedge clk); snap_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (snap_valid === 1'b1) begin
        pulses++; got = snap_value;
        n_checks++; if (busy !== 1'b0 || running !== 1'b1) begin n_fail++;
          $display("FAIL snap_return: busy=%b running=%b want 0 1", busy, running); end
      end
      @(negedge clk);
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL snap_pulses: got %0d want 1", pulses); end
    n_checks++; if (got !== 32'h0002_1A3F) begin n_fail++; $display("FAIL snap_value: got %h want 00021a3f", got); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL snap_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_irq_stall();
    int ticks = 0;
    int cyc = 0;
    logic [31:0] got = '0;
    obs_q.delete();
    snap_src = 32'hDEAD_BEEF;
    exp_q.push_back(mk(1'b1, 3'd4, 16'h0));
    exp_q.push_back(mk(1'b0, 3'd4, 16'h0));
    exp_q.push_back(mk(1'b0, 3'd5, 16'h0));
    exp_q.push_back(mk(1'b1, 3'd0, 16'h0));
    snap_req = 1'b1;
    @(negedge clk); snap_req = 1'b0;
    while (!(avm_chipselect && avm_write_n && avm_address == 3'd4) && cyc < 20) begin @(negedge clk); cyc++; end
    force_req++;
    while (!(avm_chipselect && avm_write_n && avm_address == 3'd5) && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++; if (cyc >= 20) begin n_fail++; $display("FAIL stall_reach: got timeout want RD_H access"); end
    avm_waitrequest = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++; if ({avm_chipselect, avm_write_n, avm_address} !== {1'b1, 1'b1, 3'd5}) begin n_fail++;
        $display("FAIL stall_stable: cs=%b wn=%b addr=%h want 1 1 5", avm_chipselect, avm_write_n, avm_address); end
    end
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (snap_valid === 1'b1) got = snap_value;
      if (tick === 1'b1) ticks++;
    end
    n_checks++; if (got !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stall_snap: got %h want deadbeef", got); end
    n_checks++; if (ticks != 1) begin n_fail++; $display("FAIL stall_ticks: got %0d want 1", ticks); end
    n_checks++; if (tick_count !== 16'd6) begin n_fail++; $display("FAIL stall_count: got %0d want 6", tick_count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL stall_sb: got %h want %h", o, e); end
    end
  endtask

  task automatic test_stop_snap();
    int pulses = 0;
    obs_q.delete();
    exp_q.push_back(mk(1'b1, 3'd1, 16'h0008));
    cfg_stop = 1'b1; snap_req = 1'b1;
    @(negedge clk); cfg_stop = 1'b0; snap_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (snap_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL stop_snap_valid: got %0d want 0", pulses); end
    n_checks++; if (running !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL stop_state: running=%b busy=%b want 0 0", running, busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL stop_sb: got %h want %h", o, e); end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL stop_extra: got %0d extra want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    cfg_period = 32'h0001_0002; cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    while (!(avm_chipselect && avm_address == 3'd3) && cyc < 10) begin @(negedge clk); cyc++; end
    n_checks++; if (cyc >= 10) begin n_fail++; $display("FAIL rst_reach: got timeout want WR_PH access"); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1) begin n_fail++;
      $display("FAIL rst_bus: cs=%b wn=%b want 0 1", avm_chipselect, avm_write_n); end
    n_checks++; if ({busy, running, tick, snap_valid} !== 4'b0 || tick_count !== 16'h0 || snap_value !== 32'h0) begin n_fail++;
      $display("FAIL rst_outputs: flags=%b cnt=%h snap=%h want 0", {busy, running, tick, snap_valid}, tick_count, snap_value); end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    test_start(32'h0001_0002);
  endtask

  initial begin
    test_reset();
    test_start(32'h0000_1388);
    test_ticks();
    test_snapshot();
    test_irq_stall();
    test_stop_snap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
